// File: rtl/hpdmc_pkg.sv
// Shared constants for the HPDMC control interface: CSR register map,
// SDRAM command encodings, timing reset defaults and sequencer states.
package hpdmc_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_FIFO   = 3'd1;
    localparam logic [2:0] REG_TIM    = 3'd2;
    localparam logic [2:0] REG_IDELAY = 3'd3;
    localparam logic [2:0] REG_STAT   = 3'd4;

    // Commands as {ras,cas,we,cs}, asserted-high; pins carry the inverse.
    localparam logic [3:0] CMD_NOP         = 4'b0000;
    localparam logic [3:0] CMD_PRECHARGE   = 4'b1011;
    localparam logic [3:0] CMD_AUTOREFRESH = 4'b1101;
    localparam logic [3:0] CMD_LOADMODE    = 4'b1111;
    localparam logic [3:0] CMD_ACTIVATE    = 4'b1001;

    localparam logic [2:0]  TIM_RP_RST   = 3'd2;
    localparam logic [2:0]  TIM_RCD_RST  = 3'd2;
    localparam logic        TIM_CAS_RST  = 1'b0;
    localparam logic [10:0] TIM_REFI_RST = 11'd620;
    localparam logic [3:0]  TIM_RFC_RST  = 4'd6;
    localparam logic [1:0]  TIM_WR_RST   = 2'd2;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/hpdmc_cmdfifo.sv
// Synchronous command FIFO with flush; a full push is dropped, the caller
// flags overflow. Head entry is presented combinationally on dout.
module hpdmc_cmdfifo #(
    parameter int width = 27,
    parameter int log2  = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [log2:0]    level
);

    localparam int depth = 1 << log2;

    logic [width-1:0] mem [depth];
    logic [log2-1:0]  wp, rp;
    logic             do_push, do_pop;

    assign full    = (level == (log2+1)'(depth));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rp];

    always_ff @(posedge sys_clk) begin
        if (do_push)
            mem[wp] <= din;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (do_pop)
                rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/hpdmc_ctlif_seq.sv
// HPDMC control interface: CSR bank (bypass/reset/CKE, timing, IDELAY) and a
// FIFO-fed command sequencer that spaces SDRAM commands by a per-entry wait.
module hpdmc_ctlif_seq
    import hpdmc_pkg::*;
#(
    parameter logic [4:0] csr_addr  = 5'h00,
    parameter int         adr_width = 13,
    parameter int         ba_width  = 2,
    parameter int         fifo_log2 = 3,
    parameter int         tap_width = 6
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [14:0]          csr_a,
    input  logic                 csr_we,
    input  logic [31:0]          csr_di,
    output logic [31:0]          csr_do,
    output logic                 bypass,
    output logic                 sdram_rst,
    output logic                 sdram_cke,
    output logic                 sdram_cs_n,
    output logic                 sdram_we_n,
    output logic                 sdram_cas_n,
    output logic                 sdram_ras_n,
    output logic [adr_width-1:0] sdram_adr,
    output logic [ba_width-1:0]  sdram_ba,
    output logic [2:0]           tim_rp,
    output logic [2:0]           tim_rcd,
    output logic                 tim_cas,
    output logic [10:0]          tim_refi,
    output logic [3:0]           tim_rfc,
    output logic [1:0]           tim_wr,
    output logic                 idelay_rst,
    output logic                 idelay_ce,
    output logic                 idelay_inc,
    output logic                 idelay_cal,
    output logic                 seq_busy
);

    localparam int cab_w = 4 + adr_width + ba_width;
    localparam int ent_w = cab_w + 8;

    logic       csr_sel, wr;
    logic [2:0] idx;
    logic       wr_ctrl, wr_fifo, wr_tim, wr_idly, wr_stat, flush;
    logic       csr_a_unused;

    assign csr_sel      = (csr_a[14:10] == csr_addr);
    assign idx          = csr_a[2:0];
    assign wr           = csr_sel && csr_we;
    assign wr_ctrl      = wr && (idx == REG_CTRL);
    assign wr_fifo      = wr && (idx == REG_FIFO);
    assign wr_tim       = wr && (idx == REG_TIM);
    assign wr_idly      = wr && (idx == REG_IDELAY);
    assign wr_stat      = wr && (idx == REG_STAT);
    assign flush        = wr_ctrl && csr_di[3];
    assign csr_a_unused = ^csr_a[9:3];

    logic [ent_w-1:0]   fifo_dout;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [fifo_log2:0] fifo_level;

    hpdmc_cmdfifo #(.width(ent_w), .log2(fifo_log2)) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (wr_fifo),
        .pop     (fifo_pop),
        .flush   (flush),
        .din     ({csr_di[31:24], csr_di[cab_w-1:0]}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    logic                 overflow;
    logic [tap_width-1:0] tap;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bypass     <= 1'b1;
            sdram_rst  <= 1'b1;
            sdram_cke  <= 1'b0;
            tim_rp     <= TIM_RP_RST;
            tim_rcd    <= TIM_RCD_RST;
            tim_cas    <= TIM_CAS_RST;
            tim_refi   <= TIM_REFI_RST;
            tim_rfc    <= TIM_RFC_RST;
            tim_wr     <= TIM_WR_RST;
            idelay_rst <= 1'b0;
            idelay_ce  <= 1'b0;
            idelay_inc <= 1'b0;
            idelay_cal <= 1'b0;
            tap        <= '0;
            overflow   <= 1'b0;
        end else begin
            idelay_rst <= 1'b0;
            idelay_ce  <= 1'b0;
            idelay_inc <= 1'b0;
            if (wr_ctrl) begin
                bypass    <= csr_di[0];
                sdram_rst <= csr_di[1];
                sdram_cke <= csr_di[2];
            end
            if (wr_tim) begin
                tim_rp   <= csr_di[2:0];
                tim_rcd  <= csr_di[5:3];
                tim_cas  <= csr_di[6];
                tim_refi <= csr_di[17:7];
                tim_rfc  <= csr_di[21:18];
                tim_wr   <= csr_di[23:22];
            end
            if (wr_idly) begin
                idelay_rst <= csr_di[0];
                idelay_ce  <= csr_di[1];
                idelay_inc <= csr_di[2];
                idelay_cal <= csr_di[3];
                if (csr_di[0])
                    tap <= '0;
                else if (csr_di[1])
                    tap <= csr_di[2] ? tap + 1'b1 : tap - 1'b1;
            end
            if (wr_stat && csr_di[0])
                overflow <= 1'b0;
            // Placed last so a dropped push beats a same-cycle clear.
            if (wr_fifo && fifo_full)
                overflow <= 1'b1;
        end
    end

    logic [31:0] rd_data;

    always_comb begin
        rd_data = 32'd0;
        case (idx)
            REG_CTRL:   rd_data = {29'd0, sdram_cke, sdram_rst, bypass};
            REG_FIFO:   rd_data = {16'(fifo_level), 13'd0, overflow, fifo_full, fifo_empty};
            REG_TIM:    rd_data = {8'd0, tim_wr, tim_rfc, tim_refi, tim_cas, tim_rcd, tim_rp};
            REG_IDELAY: rd_data = 32'({idelay_cal, tap});
            REG_STAT:   rd_data = {31'd0, overflow};
            default:    rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            csr_do <= 32'd0;
        else
            csr_do <= csr_sel ? rd_data : 32'd0;
    end

    seq_state_t state, state_nx;
    logic [3:0] cur_cmd;
    logic [7:0] wait_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state <= SEQ_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            SEQ_IDLE:  if (fifo_pop) state_nx = SEQ_ISSUE;
            SEQ_ISSUE: state_nx = (wait_cnt == 8'd0) ? SEQ_IDLE : SEQ_WAIT;
            SEQ_WAIT:  if (wait_cnt == 8'd1) state_nx = SEQ_IDLE;
            default:   state_nx = SEQ_IDLE;
        endcase
        if (flush)
            state_nx = SEQ_IDLE;
    end

    always_comb begin
        fifo_pop = (state == SEQ_IDLE) && !fifo_empty && bypass && !flush;
        {sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cs_n} =
            (state == SEQ_ISSUE) ? ~cur_cmd : 4'hF;
        seq_busy = (state != SEQ_IDLE) || !fifo_empty;
    end

    // Head entry is captured on the pop edge so adr/ba are valid during ISSUE
    // and stay put until the next command.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cur_cmd   <= '0;
            sdram_adr <= '0;
            sdram_ba  <= '0;
            wait_cnt  <= '0;
        end else if (fifo_pop) begin
            cur_cmd   <= fifo_dout[3:0];
            sdram_adr <= fifo_dout[4 +: adr_width];
            sdram_ba  <= fifo_dout[4+adr_width +: ba_width];
            wait_cnt  <= fifo_dout[ent_w-1 -: 8];
        end else if (state == SEQ_WAIT) begin
            wait_cnt  <= wait_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_hpdmc_ctlif_seq.sv
// Scoreboard bench: reads and expected SDRAM commands are queued when issued;
// a monitor pops and compares whenever csr_do is due or the pins go active.
module tb_hpdmc_ctlif_seq;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [14:0] csr_a   = '0;
    logic        csr_we  = 1'b0;
    logic [31:0] csr_di  = '0;
    logic [31:0] csr_do;
    logic        bypass, sdram_rst, sdram_cke;
    logic        sdram_cs_n, sdram_we_n, sdram_cas_n, sdram_ras_n;
    logic [12:0] sdram_adr;
    logic [1:0]  sdram_ba;
    logic [2:0]  tim_rp, tim_rcd;
    logic        tim_cas;
    logic [10:0] tim_refi;
    logic [3:0]  tim_rfc;
    logic [1:0]  tim_wr;
    logic        idelay_rst, idelay_ce, idelay_inc, idelay_cal, seq_busy;

    hpdmc_ctlif_seq dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(csr_do), .bypass(bypass), .sdram_rst(sdram_rst),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_we_n(sdram_we_n),
        .sdram_cas_n(sdram_cas_n), .sdram_ras_n(sdram_ras_n), .sdram_adr(sdram_adr),
        .sdram_ba(sdram_ba), .tim_rp(tim_rp), .tim_rcd(tim_rcd), .tim_cas(tim_cas),
        .tim_refi(tim_refi), .tim_rfc(tim_rfc), .tim_wr(tim_wr),
        .idelay_rst(idelay_rst), .idelay_ce(idelay_ce), .idelay_inc(idelay_inc),
        .idelay_cal(idelay_cal), .seq_busy(seq_busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0]  pins;   // {ras_n,cas_n,we_n,cs_n}
        logic [12:0] adr;
        logic [1:0]  ba;
        int          gap;    // cycles since previous issue, 0 = unchecked
    } iss_t;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    iss_t        iss_q[$];
    logic        rd_flag = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic csr_wr(input logic [2:0] idx, input logic [31:0] d);
        csr_a  = {5'h00, 7'd0, idx};
        csr_di = d;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_rd_a(input logic [14:0] a, input logic [31:0] exp, input string nm);
        csr_a   = a;
        rd_flag = 1'b1;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(nm);
        @(negedge sys_clk);
        rd_flag = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string nm);
        csr_rd_a({5'h00, 7'd0, idx}, exp, nm);
    endtask

    task automatic exp_iss(input logic [3:0] p, input logic [12:0] a, input logic [1:0] b, input int g);
        iss_t e;
        e.pins = p; e.adr = a; e.ba = b; e.gap = g;
        iss_q.push_back(e);
    endtask

    initial begin : mon
        logic        armed;
        int          cyc;
        int          last;
        iss_t        e;
        logic [31:0] ev;
        string       nm;
        cyc  = 0;
        last = 0;
        forever begin
            @(posedge sys_clk);
            cyc++;
            armed = rd_flag;
            @(negedge sys_clk);
            if (armed) begin
                if (rd_exp_q.size() == 0) begin
                    chk("rd_underflow", 32'd1, 32'd0);
                end else begin
                    ev = rd_exp_q.pop_front();
                    nm = rd_name_q.pop_front();
                    chk(nm, csr_do, ev);
                end
            end
            if ({sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cs_n} != 4'hF) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue", {28'd0, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cs_n}, 32'hF);
                end else begin
                    e = iss_q.pop_front();
                    chk("issue_pins", {28'd0, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cs_n}, {28'd0, e.pins});
                    chk("issue_adr", {19'd0, sdram_adr}, {19'd0, e.adr});
                    chk("issue_ba", {30'd0, sdram_ba}, {30'd0, e.ba});
                    if (e.gap != 0)
                        chk("issue_gap", cyc - last, e.gap);
                end
                last = cyc;
            end
        end
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_csr_do", csr_do, 32'd0);
        chk("rst_pins", {28'd0, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cs_n}, 32'hF);
        chk("rst_busy", {31'd0, seq_busy}, 32'd0);
        chk("rst_refi", {21'd0, tim_refi}, 32'd620);
        sys_rst = 1'b0;
        rd(3'd0, 32'h0000_0003, "rd_ctrl_rst");
        rd(3'd2, 32'h0099_3612, "rd_tim_rst");
        rd(3'd1, 32'h0000_0001, "rd_fifo_rst");
        rd(3'd3, 32'h0000_0000, "rd_idly_rst");
        rd(3'd5, 32'h0000_0000, "rd_idx5");
        csr_rd_a({5'h01, 10'd0}, 32'h0, "rd_unselected");

        // Timing register round trip, upper bits ignored
        csr_wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, 32'h00FF_FFFF, "rd_tim_all1");
        chk("tim_refi_all1", {21'd0, tim_refi}, 32'd2047);
        chk("tim_wr_all1", {30'd0, tim_wr}, 32'd3);

        // PRECHARGE wait=3 then AUTOREFRESH 5 cycles later
        exp_iss(4'b0100, 13'h400, 2'd0, 0);
        csr_wr(3'd1, 32'h0300_400B);
        exp_iss(4'b0010, 13'h123, 2'd2, 5);
        csr_wr(3'd1, 32'h0004_123D);
        chk("busy_issue", {31'd0, seq_busy}, 32'd1);
        rd(3'd1, 32'h0001_0000, "rd_level_pushpop");
        tick(10);
        chk("busy_done", {31'd0, seq_busy}, 32'd0);
        chk("adr_held", {19'd0, sdram_adr}, 32'h123);
        chk("ba_held", {30'd0, sdram_ba}, 32'd2);

        // Held FIFO while bypass=0, released in order
        csr_wr(3'd0, 32'h6);
        rd(3'd0, 32'h6, "rd_ctrl_nobyp");
        csr_wr(3'd1, 32'h0100_033F);
        csr_wr(3'd1, 32'h0003_FFF9);
        tick(5);
        rd(3'd1, 32'h0002_0000, "rd_level2");
        exp_iss(4'b0000, 13'h033, 2'd0, 0);
        exp_iss(4'b0110, 13'h1FFF, 2'd1, 3);
        csr_wr(3'd0, 32'h7);
        tick(10);

        // Overflow, clear and flush
        csr_wr(3'd0, 32'h6);
        for (int i = 0; i < 9; i++)
            csr_wr(3'd1, 32'h0000_0001 | (i << 4));
        rd(3'd1, 32'h0008_0006, "rd_full_ovf");
        rd(3'd4, 32'h1, "rd_ovf_set");
        csr_wr(3'd4, 32'h1);
        rd(3'd4, 32'h0, "rd_ovf_clr");
        rd(3'd1, 32'h0008_0002, "rd_full_noovf");
        csr_wr(3'd0, 32'hE);
        rd(3'd1, 32'h0000_0001, "rd_flushed");
        csr_wr(3'd0, 32'h7);
        tick(5);
        chk("busy_flushed", {31'd0, seq_busy}, 32'd0);

        // IDELAY pulses and tap counter
        csr_wr(3'd3, 32'h1);
        chk("idly_rst_pulse", {31'd0, idelay_rst}, 32'd1);
        tick(1);
        chk("idly_rst_clear", {31'd0, idelay_rst}, 32'd0);
        csr_wr(3'd3, 32'h6);
        chk("idly_ce_inc", {30'd0, idelay_ce, idelay_inc}, 32'd3);
        csr_wr(3'd3, 32'h6);
        csr_wr(3'd3, 32'h6);
        csr_wr(3'd3, 32'h2);
        chk("idly_ce_dec", {30'd0, idelay_ce, idelay_inc}, 32'd2);
        rd(3'd3, 32'd2, "rd_tap2");
        csr_wr(3'd3, 32'h8);
        rd(3'd3, 32'h42, "rd_cal_tap2");
        csr_wr(3'd3, 32'h1);
        for (int i = 0; i < 65; i++)
            csr_wr(3'd3, 32'h6);
        rd(3'd3, 32'd1, "rd_tap_wrap_up");
        csr_wr(3'd3, 32'h2);
        csr_wr(3'd3, 32'h2);
        rd(3'd3, 32'd63, "rd_tap_wrap_dn");
        csr_wr(3'd3, 32'hF);
        rd(3'd3, 32'h40, "rd_tap_rst_prio");

        // Reset during a long WAIT
        exp_iss(4'b0100, 13'h000, 2'd0, 0);
        csr_wr(3'd1, 32'hC800_000B);
        csr_wr(3'd1, 32'h0000_000D);
        tick(10);
        chk("busy_wait", {31'd0, seq_busy}, 32'd1);
        sys_rst = 1'b1;
        tick(1);
        chk("mid_rst_busy", {31'd0, seq_busy}, 32'd0);
        chk("mid_rst_pins", {28'd0, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cs_n}, 32'hF);
        chk("mid_rst_adr", {19'd0, sdram_adr}, 32'd0);
        chk("mid_rst_ctrl", {29'd0, sdram_cke, sdram_rst, bypass}, 32'd3);
        chk("mid_rst_tim", {8'd0, tim_wr, tim_rfc, tim_refi, tim_cas, tim_rcd, tim_rp}, 32'h0099_3612);
        chk("mid_rst_idly", {28'd0, idelay_rst, idelay_ce, idelay_inc, idelay_cal}, 32'd0);
        chk("mid_rst_csr_do", csr_do, 32'd0);
        sys_rst = 1'b0;
        rd(3'd1, 32'h0000_0001, "rd_rst_empty");
        rd(3'd3, 32'h0, "rd_rst_tap");
        tick(20);

        for (int i = 0; i < 50 && (iss_q.size() != 0 || rd_exp_q.size() != 0); i++)
            tick(1);
        chk("pending_issues", iss_q.size(), 32'd0);
        chk("pending_reads", rd_exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
